// File: rtl/pad_spi_wb_bridge.sv
// SPI (mode 0) slave to Wishbone master bridge: 0x01 A D[31:0] writes, 0x02 A dummy
// reads; the SPI pads are oversampled in the wb_clk_i domain.
module pad_spi_wb_bridge #(
    parameter logic [31:0] ADDR_BASE  = 32'h3000_0000,
    parameter int unsigned WB_TIMEOUT = 32
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        spi_sck_i,
    input  logic        spi_csb_i,
    input  logic        spi_mosi_i,
    output logic        spi_miso_o,
    output logic        spi_miso_oeb_o,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [3:0]  wbm_sel_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    input  logic [31:0] wbm_dat_i,
    input  logic        wbm_ack_i,
    output logic        status_err_o
);

    localparam int            TW        = $clog2(WB_TIMEOUT + 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(WB_TIMEOUT - 1);
    localparam logic [7:0]    CMD_WRITE = 8'h01;
    localparam logic [7:0]    CMD_READ  = 8'h02;

    typedef enum logic [3:0] {
        IDLE, CMD, ADDR, WDATA, WB_WR, WB_RD, DUMMY, RDATA, IGNORE
    } state_t;

    logic sck_meta, sck_sync, sck_prev;
    logic csb_meta, csb_sync;
    logic mosi_meta, mosi_sync;
    logic sck_rise, sck_fall;

    state_t        state, state_n;
    logic [5:0]    bit_cnt, bit_cnt_n;
    logic [7:0]    byte_sr, byte_sr_n, byte_in;
    logic          is_read, is_read_n;
    logic [31:0]   adr_n, dat_n;
    logic [31:0]   rd_sr, rd_sr_n;
    logic [TW-1:0] wb_cnt, wb_cnt_n;
    logic          miso_n, err_n;
    logic          abort_q, abort_n;
    logic          wb_done;

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge value; blocking here would collapse the 2-FF chain into one.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            sck_meta  <= 1'b0;
            sck_sync  <= 1'b0;
            sck_prev  <= 1'b0;
            csb_meta  <= 1'b1;
            csb_sync  <= 1'b1;
            mosi_meta <= 1'b0;
            mosi_sync <= 1'b0;
        end else begin
            sck_meta  <= spi_sck_i;
            sck_sync  <= sck_meta;
            sck_prev  <= sck_sync;
            csb_meta  <= spi_csb_i;
            csb_sync  <= csb_meta;
            mosi_meta <= spi_mosi_i;
            mosi_sync <= mosi_meta;
        end
    end

    assign sck_rise = sck_sync & ~sck_prev;
    assign sck_fall = ~sck_sync & sck_prev;

    assign wbm_cyc_o      = (state == WB_WR) || (state == WB_RD);
    assign wbm_stb_o      = wbm_cyc_o;
    assign wbm_we_o       = (state == WB_WR);
    assign wbm_sel_o      = {4{wbm_cyc_o}};
    assign spi_miso_oeb_o = csb_sync;

    assign byte_in = {byte_sr[6:0], mosi_sync};
    assign wb_done = wbm_ack_i || (wb_cnt == TO_LAST);

    // NOTE: every variable gets a default before the case so no path infers a latch.
    always_comb begin
        state_n   = state;
        bit_cnt_n = bit_cnt;
        byte_sr_n = byte_sr;
        is_read_n = is_read;
        adr_n     = wbm_adr_o;
        dat_n     = wbm_dat_o;
        rd_sr_n   = rd_sr;
        wb_cnt_n  = wb_cnt;
        miso_n    = 1'b0;
        err_n     = status_err_o;
        abort_n   = abort_q;

        case (state)
            IDLE: begin
                if (!csb_sync) begin
                    state_n   = CMD;
                    bit_cnt_n = '0;
                end
            end
            CMD: begin
                if (sck_rise) begin
                    byte_sr_n = byte_in;
                    bit_cnt_n = bit_cnt + 6'd1;
                    if (bit_cnt == 6'd7) begin
                        bit_cnt_n = '0;
                        is_read_n = (byte_in == CMD_READ);
                        state_n   = (byte_in == CMD_WRITE || byte_in == CMD_READ) ? ADDR : IGNORE;
                    end
                end
            end
            ADDR: begin
                if (sck_rise) begin
                    byte_sr_n = byte_in;
                    bit_cnt_n = bit_cnt + 6'd1;
                    if (bit_cnt == 6'd7) begin
                        bit_cnt_n = '0;
                        adr_n     = ADDR_BASE | {22'b0, byte_in, 2'b00};
                        wb_cnt_n  = '0;
                        abort_n   = 1'b0;
                        state_n   = is_read ? WB_RD : WDATA;
                    end
                end
            end
            WDATA: begin
                if (sck_rise) begin
                    dat_n     = {wbm_dat_o[30:0], mosi_sync};
                    bit_cnt_n = bit_cnt + 6'd1;
                    if (bit_cnt == 6'd31) begin
                        bit_cnt_n = '0;
                        wb_cnt_n  = '0;
                        abort_n   = 1'b0;
                        state_n   = WB_WR;
                    end
                end
            end
            WB_WR, WB_RD: begin
                // A CSB release here is remembered; the bus cycle always runs to its end.
                if (csb_sync) abort_n = 1'b1;
                if (wbm_ack_i) begin
                    if (state == WB_RD) rd_sr_n = wbm_dat_i;
                end else if (wb_cnt == TO_LAST) begin
                    err_n = 1'b1;
                    if (state == WB_RD) rd_sr_n = '1;
                end else begin
                    wb_cnt_n = wb_cnt + TW'(1);
                end
                if (wb_done) begin
                    bit_cnt_n = '0;
                    if (abort_q || csb_sync) state_n = IDLE;
                    else                     state_n = (state == WB_RD) ? DUMMY : IGNORE;
                end
            end
            DUMMY: begin
                if (sck_rise) begin
                    bit_cnt_n = bit_cnt + 6'd1;
                    if (bit_cnt == 6'd7) begin
                        bit_cnt_n = '0;
                        miso_n    = rd_sr[31];
                        state_n   = RDATA;
                    end
                end
            end
            RDATA: begin
                miso_n = spi_miso_o;
                if (sck_rise) begin
                    bit_cnt_n = bit_cnt + 6'd1;
                    if (bit_cnt == 6'd31) begin
                        miso_n  = 1'b0;
                        state_n = IGNORE;
                    end
                end else if (sck_fall && bit_cnt != 6'd0) begin
                    // Bit 31 was presented on entry, so shift only after the master sampled it.
                    rd_sr_n = {rd_sr[30:0], 1'b0};
                    miso_n  = rd_sr[30];
                end
            end
            IGNORE: ;
            default: state_n = IDLE;
        endcase

        if (csb_sync && state inside {CMD, ADDR, WDATA, DUMMY, RDATA, IGNORE}) begin
            state_n = IDLE;
            miso_n  = 1'b0;
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state        <= IDLE;
            bit_cnt      <= '0;
            byte_sr      <= '0;
            is_read      <= 1'b0;
            wbm_adr_o    <= '0;
            wbm_dat_o    <= '0;
            rd_sr        <= '0;
            wb_cnt       <= '0;
            spi_miso_o   <= 1'b0;
            status_err_o <= 1'b0;
            abort_q      <= 1'b0;
        end else begin
            state        <= state_n;
            bit_cnt      <= bit_cnt_n;
            byte_sr      <= byte_sr_n;
            is_read      <= is_read_n;
            wbm_adr_o    <= adr_n;
            wbm_dat_o    <= dat_n;
            rd_sr        <= rd_sr_n;
            wb_cnt       <= wb_cnt_n;
            spi_miso_o   <= miso_n;
            status_err_o <= err_n;
            abort_q      <= abort_n;
        end
    end

endmodule

// File: tb/tb_pad_spi_wb_bridge.sv
// Self-checking bench for pad_spi_wb_bridge: SPI master at wb_clk/8, Wishbone slave
// with programmable ack latency, transaction-level reference model.
`timescale 1ns/1ps
module tb_pad_spi_wb_bridge;

    localparam logic [31:0] BASE    = 32'h3000_0000;
    localparam int          TIMEOUT = 32;
    localparam int          NEVER   = 1000;

    logic        clk  = 1'b0;
    logic        rst  = 1'b1;
    logic        sck  = 1'b0;
    logic        csb  = 1'b1;
    logic        mosi = 1'b0;
    logic        miso, oeb, cyc, stb, we, err;
    logic        ack  = 1'b0;
    logic [3:0]  sel;
    logic [31:0] adr, dat_o;
    logic [31:0] dat_i = '0;

    always #5 clk = ~clk;

    pad_spi_wb_bridge #(.ADDR_BASE(BASE), .WB_TIMEOUT(TIMEOUT)) dut (
        .wb_clk_i      (clk),
        .wb_rst_i      (rst),
        .spi_sck_i     (sck),
        .spi_csb_i     (csb),
        .spi_mosi_i    (mosi),
        .spi_miso_o    (miso),
        .spi_miso_oeb_o(oeb),
        .wbm_cyc_o     (cyc),
        .wbm_stb_o     (stb),
        .wbm_we_o      (we),
        .wbm_sel_o     (sel),
        .wbm_adr_o     (adr),
        .wbm_dat_o     (dat_o),
        .wbm_dat_i     (dat_i),
        .wbm_ack_i     (ack),
        .status_err_o  (err)
    );

    int checks = 0;
    int passed = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passed++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // Wishbone slave: acks after ack_delay cycles of an active strobe.
    int          ack_delay  = 0;
    int          slave_cnt  = 0;
    logic [31:0] slave_data = '0;

    always @(posedge clk) begin
        if (cyc && stb && !ack) begin
            if (slave_cnt >= ack_delay) begin
                ack   <= 1'b1;
                dat_i <= slave_data;
            end else begin
                slave_cnt <= slave_cnt + 1;
            end
        end else begin
            ack       <= 1'b0;
            slave_cnt <= 0;
        end
    end

    // Bus monitor: one record per Wishbone cycle, plus its length in clocks.
    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
    } txn_t;

    txn_t txq[$];
    txn_t mon_t;
    int   cyc_len   = 0;
    int   last_len  = 0;
    int   proto_err = 0;
    logic cyc_q     = 1'b0;

    always @(negedge clk) begin
        if (cyc !== stb) proto_err++;
        if (cyc === 1'b1 && cyc_q !== 1'b1) begin
            mon_t.we  = we;
            mon_t.adr = adr;
            mon_t.dat = dat_o;
            mon_t.sel = sel;
            txq.push_back(mon_t);
            cyc_len = 1;
        end else if (cyc === 1'b1) begin
            cyc_len++;
        end else if (cyc_q === 1'b1) begin
            last_len = cyc_len;
        end
        cyc_q = cyc;
    end

    function automatic logic [31:0] exp_adr(input logic [7:0] a);
        return BASE + 32'(a) * 32'd4;
    endfunction

    // SPI mode-0 master: MOSI set while SCK low, MISO sampled at the rising edge.
    task automatic spi_bits(input logic [31:0] tx, input int n, output logic [31:0] rx);
        rx = '0;
        for (int i = n - 1; i >= 0; i--) begin
            mosi = tx[i];
            repeat (4) @(negedge clk);
            rx  = {rx[30:0], miso};
            sck = 1'b1;
            repeat (4) @(negedge clk);
            sck = 1'b0;
        end
    endtask

    task automatic cs_low();
        csb = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic cs_high();
        repeat (4) @(negedge clk);
        csb  = 1'b1;
        mosi = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    task automatic do_write(input logic [7:0] a, input logic [31:0] d, input int extra);
        logic [31:0] junk;
        cs_low();
        spi_bits(32'h01, 8, junk);
        spi_bits(32'(a), 8, junk);
        spi_bits(d, 32, junk);
        repeat (48) @(negedge clk);
        for (int i = 0; i < extra; i++) spi_bits($urandom, 8, junk);
        cs_high();
    endtask

    // The SCK pause after the address byte leaves room for the bus cycle to finish.
    task automatic do_read(input logic [7:0] a, output logic [31:0] rx);
        logic [31:0] junk;
        cs_low();
        spi_bits(32'h02, 8, junk);
        spi_bits(32'(a), 8, junk);
        repeat (48) @(negedge clk);
        spi_bits($urandom, 8, junk);
        spi_bits(32'h0, 32, rx);
        cs_high();
    endtask

    task automatic expect_txn(input string tag, input logic exp_we, input logic [31:0] exp_a,
                              input logic [31:0] exp_d, input bit chk_dat);
        txn_t t;
        check({tag, "_count"}, 32'(txq.size()), 32'd1);
        if (txq.size() > 0) begin
            t = txq.pop_front();
            check({tag, "_we"},  32'(t.we),  32'(exp_we));
            check({tag, "_adr"}, t.adr,      exp_a);
            check({tag, "_sel"}, 32'(t.sel), 32'hF);
            if (chk_dat) check({tag, "_dat"}, t.dat, exp_d);
        end
        txq.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cyc"},  32'(cyc),   32'd0);
        check({tag, "_stb"},  32'(stb),   32'd0);
        check({tag, "_we"},   32'(we),    32'd0);
        check({tag, "_sel"},  32'(sel),   32'd0);
        check({tag, "_adr"},  adr,        32'd0);
        check({tag, "_dat"},  dat_o,      32'd0);
        check({tag, "_miso"}, 32'(miso),  32'd0);
        check({tag, "_oeb"},  32'(oeb),   32'd1);
        check({tag, "_err"},  32'(err),   32'd0);
    endtask

    initial begin
        logic [31:0] rx, acc, d;
        logic [7:0]  a;
        bit          is_rd, seen;

        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // Directed write
        ack_delay = 1;
        do_write(8'h05, 32'hCAFE_F00D, 0);
        expect_txn("wr", 1'b1, 32'h3000_0014, 32'hCAFE_F00D, 1'b1);
        check("wr_err", 32'(err), 32'd0);

        // Directed read, slave acks after 3 cycles
        ack_delay  = 3;
        slave_data = 32'h1234_5678;
        do_read(8'h10, rx);
        expect_txn("rd", 1'b0, 32'h3000_0040, '0, 1'b0);
        check("rd_miso", rx, 32'h1234_5678);

        // Unknown command followed by six bytes
        cs_low();
        spi_bits(32'h7E, 8, rx);
        acc = '0;
        for (int i = 0; i < 6; i++) begin
            spi_bits($urandom, 8, rx);
            acc |= rx;
        end
        check("unk_miso_bits", acc, 32'd0);
        check("unk_oeb", 32'(oeb), 32'd0);
        check("unk_miso", 32'(miso), 32'd0);
        cs_high();
        check("unk_txn", 32'(txq.size()), 32'd0);

        // Abort after 20 of 32 data bits, then a clean write
        cs_low();
        spi_bits(32'h01, 8, rx);
        spi_bits(32'h00, 8, rx);
        spi_bits($urandom, 20, rx);
        cs_high();
        repeat (48) @(negedge clk);
        check("abort_txn", 32'(txq.size()), 32'd0);
        ack_delay = 0;
        do_write(8'h00, 32'h0000_0001, 0);
        expect_txn("abort_next", 1'b1, 32'h3000_0000, 32'h0000_0001, 1'b1);

        // Read timeout: slave never acks
        ack_delay = NEVER;
        do_read(8'hA5, rx);
        expect_txn("to", 1'b0, exp_adr(8'hA5), '0, 1'b0);
        check("to_len", 32'(last_len), 32'(TIMEOUT));
        check("to_miso", rx, 32'hFFFF_FFFF);
        check("to_err", 32'(err), 32'd1);

        // Randomised traffic; the error flag must stay set throughout
        for (int n = 0; n < 12; n++) begin
            is_rd     = 1'($urandom_range(0, 1));
            a         = 8'($urandom);
            d         = $urandom;
            ack_delay = $urandom_range(0, 20);
            if (is_rd) begin
                slave_data = d;
                do_read(a, rx);
                expect_txn("rnd_rd", 1'b0, exp_adr(a), '0, 1'b0);
                check("rnd_rd_miso", rx, d);
            end else begin
                do_write(a, d, $urandom_range(0, 2));
                expect_txn("rnd_wr", 1'b1, exp_adr(a), d, 1'b1);
            end
            check("rnd_err", 32'(err), 32'd1);
        end

        // Reset asserted while a write cycle is stalled on the bus
        ack_delay = NEVER;
        cs_low();
        spi_bits(32'h01, 8, rx);
        spi_bits(32'h3C, 8, rx);
        spi_bits(32'hDEAD_BEEF, 32, rx);
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (cyc === 1'b1) seen = 1'b1;
        end
        check("rm_cyc_seen", 32'(seen), 32'd1);
        rst = 1'b1;
        #1;
        check("rm_cyc_drop", 32'(cyc), 32'd0);
        check("rm_stb_drop", 32'(stb), 32'd0);
        csb  = 1'b1;
        sck  = 1'b0;
        mosi = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check_reset_outputs("rm_post");
        txq.delete();
        ack_delay = 2;
        do_write(8'h3C, 32'h0BAD_F00D, 0);
        expect_txn("rm_wr", 1'b1, exp_adr(8'h3C), 32'h0BAD_F00D, 1'b1);
        check("rm_err", 32'(err), 32'd0);

        check("cyc_eq_stb", 32'(proto_err), 32'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/pad_spi_wb_bridge.md
PAD_SPI_WB_BRIDGE -- requirements
Module: pad_spi_wb_bridge

Interface
REQ-001 SHALL have parameter ADDR_BASE, default 32'h3000_0000: base OR-ed into every Wishbone address.
REQ-002 SHALL have parameter WB_TIMEOUT, default 32: the maximum number of wb_clk_i cycles to wait for wbm_ack_i.
REQ-003 SHALL have port wb_clk_i, input, 1 bit: the single clock for the block.
REQ-004 SHALL have port wb_rst_i, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port spi_sck_i, input, 1 bit: SPI clock from the pad, asynchronous to wb_clk_i.
REQ-006 SHALL have port spi_csb_i, input, 1 bit: SPI chip select from the pad, active-low.
REQ-007 SHALL have port spi_mosi_i, input, 1 bit: SPI serial data in.
REQ-008 SHALL have port spi_miso_o, output, 1 bit: SPI serial data out.
REQ-009 SHALL have port spi_miso_oeb_o, output, 1 bit: MISO pad output enable, active-low.
REQ-010 SHALL have ports wbm_cyc_o, wbm_stb_o, wbm_we_o, each output, 1 bit: Wishbone master controls toward accel_core.
REQ-011 SHALL have port wbm_sel_o, output, 4 bits: byte selects.
REQ-012 SHALL have ports wbm_adr_o and wbm_dat_o, each output, 32 bits: Wishbone address and write data.
REQ-013 SHALL have port wbm_dat_i, input, 32 bits: Wishbone read data.
REQ-014 SHALL have port wbm_ack_i, input, 1 bit: Wishbone acknowledge.
REQ-015 SHALL have port status_err_o, output, 1 bit: sticky flag, set on Wishbone timeout.

Function
REQ-016 SHALL pass spi_sck_i, spi_csb_i and spi_mosi_i through 2-FF synchronizers, and detect SCK edges on the synchronized SCK; supported SCK frequency is at most wb_clk_i/8.
REQ-017 SHALL use SPI mode 0: sample MOSI on the rising SCK edge, change MISO after the falling SCK edge, MSB first.
REQ-018 SHALL implement states IDLE, CMD, ADDR, WDATA, WB_WR, WB_RD, DUMMY, RDATA, IGNORE.
REQ-019 SHALL move IDLE->CMD when synchronized CSB goes low, with the bit counter cleared.
REQ-020 SHALL, on the 8th bit in CMD: go to ADDR for command 0x01 (write) or 0x02 (read); go to IGNORE for any other command.
REQ-021 SHALL, on the 8th bit in ADDR: latch A[7:0] and set wbm_adr_o = ADDR_BASE | {22'b0, A, 2'b00}; write goes to WDATA, read goes to WB_RD.
REQ-022 SHALL, in WDATA, shift 32 bits MSB first into wbm_dat_o, then enter WB_WR.
REQ-023 SHALL, in WB_WR or WB_RD, assert wbm_cyc_o=wbm_stb_o=1, wbm_sel_o=4'hF, and wbm_we_o=1 for WB_WR / 0 for WB_RD.
REQ-024 SHALL hold the Wishbone strobe until wbm_ack_i=1 or WB_TIMEOUT cycles elapse, then deassert cyc/stb/we on the next cycle.
REQ-025 SHALL, on a WB_RD ack, capture wbm_dat_i into the read shift register.
REQ-026 SHALL, on a WB_RD timeout, load 32'hFFFF_FFFF and set status_err_o; a WB_WR timeout also sets status_err_o.
REQ-027 SHALL go WB_WR->IGNORE and WB_RD->DUMMY after the Wishbone cycle ends.
REQ-028 SHALL, in DUMMY, count 8 rising edges regardless of MOSI, then enter RDATA.
REQ-029 SHALL present read-register bit 31 on spi_miso_o on entry to RDATA, and shift one bit per falling edge thereafter.
REQ-030 SHALL enter IGNORE after 32 bits in RDATA, driving spi_miso_o=0.
REQ-031 SHALL keep spi_miso_oeb_o=0 while synchronized CSB is low, and 1 otherwise.
REQ-032 SHALL, when CSB rises mid-transfer, discard any partial byte or word, issue no new Wishbone cycle, and return to IDLE.
REQ-033 SHALL, if CSB rises during WB_WR or WB_RD, complete the Wishbone cycle (ack or timeout) before returning to IDLE; the read data is then dropped.
REQ-034 SHALL never let a new CSB assertion start a transfer before an earlier Wishbone cycle has finished.
REQ-035 SHALL ignore extra bytes after a completed write or read; there is no auto-increment.
REQ-036 SHALL issue at most one outstanding Wishbone cycle, and wbm_cyc_o SHALL equal wbm_stb_o at all times.

Reset
REQ-037 SHALL, while wb_rst_i=1, asynchronously force: state IDLE; wbm_cyc_o, wbm_stb_o, wbm_we_o = 0; wbm_sel_o = 0; wbm_adr_o = 0; wbm_dat_o = 0; spi_miso_o = 0; spi_miso_oeb_o = 1; status_err_o = 0; synchronizers cleared, with CSB synchronizer = 1.
REQ-038 SHALL, on reset assertion mid-transaction, abandon the transaction immediately and drop cyc/stb.
REQ-039 SHALL clear status_err_o only by reset.

Verification
REQ-040 SHALL verify a write: SCK=wb_clk/8, send 0x01, 0x05, 0xCAFEF00D -> exactly one Wishbone write with adr 0x3000_0014, dat 0xCAFEF00D, sel 0xF, we=1; the ack ends the cycle.
REQ-041 SHALL verify a read: send 0x02, 0x10, a dummy byte, then 32 clocks, with slave data 0x12345678 acked after 3 cycles -> adr 0x3000_0040, we=0; MISO shifts out 0x12345678 MSB first.
REQ-042 SHALL verify a read timeout: a read with the slave never acking -> cyc drops after 32 cycles; MISO returns 0xFFFFFFFF; status_err_o=1 and stays 1 until reset.
REQ-043 SHALL verify an abort: CSB rises after 20 of 32 write-data bits -> no Wishbone cycle; the next transfer (0x01, 0x00, 0x00000001) writes 0x3000_0000 correctly.
REQ-044 SHALL verify an unknown command: command 0x7E followed by 6 bytes -> no Wishbone activity; MISO=0 and oeb=0 while CSB is low.
REQ-045 SHALL verify reset mid-operation: assert wb_rst_i during WB_WR -> cyc/stb=0 the same cycle; after release, outputs hold their reset values and a fresh write succeeds.
